// File: rtl/hcsr04_echo.sv
// HC-SR04 echo-pulse timer.
// Synchronises the echo pin, times its high phase in microseconds, and
// converts the result to centimetres with a running sub-counter rather
// than a divider. A window counter started at arm time aborts
// measurements that never see an echo, or whose echo never falls.
module hcsr04_echo #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int US_DIV     = 50,
    parameter int TIMEOUT_US = 30000,
    parameter int CM_DIV     = 58
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        echo,
    output logic        busy,
    output logic        valid,
    output logic        timeout,
    output logic [15:0] pulse_us,
    output logic [9:0]  distance_cm
);

    // US_DIV of 0 means "derive the microsecond divider from CLK_HZ".
    localparam int US_EFF    = (US_DIV > 0) ? US_DIV : (CLK_HZ / 1_000_000);
    localparam int WIN_LIMIT = TIMEOUT_US * US_EFF;
    localparam int WIN_W     = $clog2(WIN_LIMIT + 1);
    localparam int PRE_W     = (US_EFF > 1) ? $clog2(US_EFF) : 1;
    localparam int CMS_W     = (CM_DIV > 1) ? $clog2(CM_DIV) : 1;

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LIMIT - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(US_EFF - 1);
    localparam logic [CMS_W-1:0] CMS_LAST = CMS_W'(CM_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_WAIT_RISE = 2'd1,
        S_MEASURE   = 2'd2,
        S_REPORT    = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic              echo_meta_q, echo_sync_q, echo_prev_q;
    logic [WIN_W-1:0]  win_q, win_d;
    logic [PRE_W-1:0]  presc_q, presc_d;
    logic [CMS_W-1:0]  cm_sub_q, cm_sub_d;
    logic [15:0]       pulse_cnt_q, pulse_cnt_d;
    logic [9:0]        cm_cnt_q, cm_cnt_d;
    logic              valid_q, valid_d;
    logic              timeout_q, timeout_d;
    logic [15:0]       pulse_us_q, pulse_us_d;
    logic [9:0]        distance_q, distance_d;

    logic              echo_rise, echo_fall, win_expired;
    logic              us_tick, cm_tick;
    logic [PRE_W-1:0]  presc_adv;
    logic [CMS_W-1:0]  cm_sub_adv;
    logic [15:0]       pulse_adv;
    logic [9:0]        cm_adv;

    // Two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            echo_meta_q <= 1'b0;
            echo_sync_q <= 1'b0;
            echo_prev_q <= 1'b0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    assign echo_rise   =  echo_sync_q & ~echo_prev_q;
    assign echo_fall   = ~echo_sync_q &  echo_prev_q;
    assign win_expired = (win_q == WIN_LAST);

    // Counter advance for one measuring cycle; the fall cycle itself is
    // counted too so the synchroniser delay cancels between both edges.
    always_comb begin
        us_tick    = (presc_q == PRE_LAST);
        cm_tick    = us_tick && (cm_sub_q == CMS_LAST);
        presc_adv  = us_tick ? '0 : presc_q + PRE_W'(1);
        cm_sub_adv = cm_sub_q;
        if (us_tick) begin
            cm_sub_adv = (cm_sub_q == CMS_LAST) ? '0 : cm_sub_q + CMS_W'(1);
        end
        pulse_adv = pulse_cnt_q;
        if (us_tick && pulse_cnt_q != 16'hFFFF) begin
            pulse_adv = pulse_cnt_q + 16'd1;
        end
        cm_adv = cm_cnt_q;
        if (cm_tick && cm_cnt_q != 10'h3FF) begin
            cm_adv = cm_cnt_q + 10'd1;
        end
    end

    // Next-state, counter and result logic.
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        presc_d     = presc_q;
        cm_sub_d    = cm_sub_q;
        pulse_cnt_d = pulse_cnt_q;
        cm_cnt_d    = cm_cnt_q;
        valid_d     = 1'b0;
        timeout_d   = 1'b0;
        pulse_us_d  = pulse_us_q;
        distance_d  = distance_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_WAIT_RISE;
                    win_d   = '0;
                end
            end
            S_WAIT_RISE: begin
                win_d = win_q + WIN_W'(1);
                if (win_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end else if (echo_rise) begin
                    state_d     = S_MEASURE;
                    presc_d     = '0;
                    cm_sub_d    = '0;
                    pulse_cnt_d = '0;
                    cm_cnt_d    = '0;
                end
            end
            S_MEASURE: begin
                win_d       = win_q + WIN_W'(1);
                presc_d     = presc_adv;
                cm_sub_d    = cm_sub_adv;
                pulse_cnt_d = pulse_adv;
                cm_cnt_d    = cm_adv;
                // A fall wins over a simultaneous window expiry.
                if (echo_fall) begin
                    state_d    = S_REPORT;
                    valid_d    = 1'b1;
                    pulse_us_d = pulse_adv;
                    distance_d = cm_adv;
                end else if (win_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_REPORT: begin
                // Results were latched on entry; valid is up this cycle.
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, counters and result registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            win_q       <= '0;
            presc_q     <= '0;
            cm_sub_q    <= '0;
            pulse_cnt_q <= '0;
            cm_cnt_q    <= '0;
            valid_q     <= 1'b0;
            timeout_q   <= 1'b0;
            pulse_us_q  <= '0;
            distance_q  <= '0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            presc_q     <= presc_d;
            cm_sub_q    <= cm_sub_d;
            pulse_cnt_q <= pulse_cnt_d;
            cm_cnt_q    <= cm_cnt_d;
            valid_q     <= valid_d;
            timeout_q   <= timeout_d;
            pulse_us_q  <= pulse_us_d;
            distance_q  <= distance_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign valid       = valid_q;
    assign timeout     = timeout_q;
    assign pulse_us    = pulse_us_q;
    assign distance_cm = distance_q;

endmodule

// File: tb/tb_hcsr04_echo.sv
// Scoreboard bench for hcsr04_echo, run with a 4-cycle microsecond so the
// full scenario set stays short.
module tb_hcsr04_echo;

    localparam int US_DIV     = 4;
    localparam int TIMEOUT_US = 2000;
    localparam int CM_DIV     = 58;
    localparam int LIMIT      = TIMEOUT_US * US_DIV;

    logic        clk = 1'b0;
    logic        reset, start, echo;
    logic        busy, valid, timeout;
    logic [15:0] pulse_us;
    logic [9:0]  distance_cm;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        bit          is_timeout;
        logic [15:0] pulse;
        logic [9:0]  cm;
        int          at_cyc;
    } exp_t;

    exp_t exp_q[$];
    logic prev_valid = 1'b0;

    hcsr04_echo #(
        .CLK_HZ     (4_000_000),
        .US_DIV     (US_DIV),
        .TIMEOUT_US (TIMEOUT_US),
        .CM_DIV     (CM_DIV)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .echo        (echo),
        .busy        (busy),
        .valid       (valid),
        .timeout     (timeout),
        .pulse_us    (pulse_us),
        .distance_cm (distance_cm)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge n, cyc == n.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic push_result(input bit is_to, input int ncyc, input int at);
        exp_t e;
        int   us;
        us = ncyc / US_DIV;
        if (us > 16'hFFFF) us = 16'hFFFF;
        e.is_timeout = is_to;
        e.pulse      = 16'(us);
        e.cm         = ((us / CM_DIV) > 10'h3FF) ? 10'h3FF : 10'(us / CM_DIV);
        e.at_cyc     = at;
        exp_q.push_back(e);
    endtask

    task automatic push_timeout(input logic [15:0] p, input logic [9:0] c, input int at);
        exp_t e;
        e.is_timeout = 1'b1;
        e.pulse      = p;
        e.cm         = c;
        e.at_cyc     = at;
        exp_q.push_back(e);
    endtask

    // Event monitor: every valid/timeout pulse is matched against the queue.
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_valid) check_eq("busy_after_valid", busy, 0);
            if (valid || timeout) begin
                check_eq("valid_timeout_excl", valid & timeout, 0);
                if (exp_q.size() == 0) begin
                    check_eq("spurious_event", {valid, timeout}, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("event at cycle %0d: valid=%0b timeout=%0b pulse_us=%0d distance_cm=%0d",
                             cyc, valid, timeout, pulse_us, distance_cm);
                    check_eq("event_kind", timeout, e.is_timeout);
                    check_eq("event_cycle", cyc, e.at_cyc);
                    check_eq("pulse_us", pulse_us, e.pulse);
                    check_eq("distance_cm", distance_cm, e.cm);
                end
            end
        end
        prev_valid <= valid && !reset;
    end

    // Pulse start; returns the acceptance edge number.
    task automatic do_start(output int s);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        s = cyc;
        check_eq("busy_after_start", busy, 1);
    endtask

    // Echo high for ncyc cycles; optionally pokes start at cycle poke_at.
    task automatic echo_pulse(input int ncyc, input int poke_at);
        echo = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            start = (i == poke_at);
            @(negedge clk);
        end
        start = 1'b0;
        echo  = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_eq("idle_wait", busy, 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_busy"}, busy, 0);
        check_eq({tag, "_valid"}, valid, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
        check_eq({tag, "_pulse_us"}, pulse_us, 0);
        check_eq({tag, "_distance_cm"}, distance_cm, 0);
    endtask

    initial begin
        int s;
        int n;
        reset = 1'b1;
        start = 1'b0;
        echo  = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 580 us -> 580 us, 10 cm
        do_start(s);
        repeat (5) @(negedge clk);
        echo_pulse(580 * US_DIV, -1);
        push_result(1'b0, 580 * US_DIV, cyc + 3);
        wait_idle(50);

        // 57 us -> 57 us, 0 cm; a start mid-echo must be ignored
        do_start(s);
        repeat (5) @(negedge clk);
        echo_pulse(57 * US_DIV, 100);
        push_result(1'b0, 57 * US_DIV, cyc + 3);
        wait_idle(50);

        // No echo: timeout LIMIT cycles after acceptance, outputs held
        do_start(s);
        push_timeout(16'd57, 10'd0, s + LIMIT);
        wait_idle(LIMIT + 50);
        check_eq("hold_pulse_us", pulse_us, 57);
        check_eq("hold_distance_cm", distance_cm, 0);

        // Echo already high at start is not a rise
        echo = 1'b1;
        repeat (20) @(negedge clk);
        do_start(s);
        repeat (10) @(negedge clk);
        echo = 1'b0;
        repeat (US_DIV) @(negedge clk);
        echo_pulse(116 * US_DIV, -1);
        push_result(1'b0, 116 * US_DIV, cyc + 3);
        wait_idle(50);

        // Fall and window expiry on the same edge resolve as a fall
        do_start(s);
        repeat (10) @(negedge clk);
        n = (s + LIMIT - 3) - cyc;
        echo_pulse(n, -1);
        push_result(1'b0, n, s + LIMIT);
        wait_idle(50);

        // Start during MEASURE ignored, then reset aborts mid-echo
        do_start(s);
        repeat (5) @(negedge clk);
        echo = 1'b1;
        for (int i = 0; i < 200; i++) begin
            start = (i == 50);
            @(negedge clk);
        end
        start = 1'b0;
        check_eq("busy_mid_echo", busy, 1);
        reset = 1'b1;
        #1;
        check_all_zero("abort");
        repeat (3) @(negedge clk);
        echo  = 1'b0;
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_all_zero("post_reset");

        // First measurement after reset: 290 us -> 5 cm
        do_start(s);
        repeat (5) @(negedge clk);
        echo_pulse(290 * US_DIV, -1);
        push_result(1'b0, 290 * US_DIV, cyc + 3);
        wait_idle(50);

        repeat (10) @(negedge clk);
        check_eq("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish (checks %0d, errors %0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/hcsr04_echo.md
HCSR04_ECHO -- requirements
Module: hcsr04_echo

Interface
REQ-001 Parameter CLK_HZ, default 50_000_000, system clock frequency.
REQ-002 Parameter US_DIV, default 50, clock cycles per microsecond tick.
REQ-003 Parameter TIMEOUT_US, default 30000, measurement window in microseconds, counted from start acceptance.
REQ-004 Parameter CM_DIV, default 58, microseconds per centimetre of range.
REQ-005 clk  input  1  system clock; all state SHALL update on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  one-cycle request to arm a measurement, issued when the trigger pulse ends.
REQ-008 echo  input  1  HC-SR04 echo pin, asynchronous to clk.
REQ-009 busy  output  1  high while a measurement is armed or in progress.
REQ-010 valid  output  1  one-cycle pulse; pulse_us and distance_cm are updated in the same cycle.
REQ-011 timeout  output  1  one-cycle pulse on measurement window expiry.
REQ-012 pulse_us  output  16  measured echo high time in whole microseconds.
REQ-013 distance_cm  output  10  measured range in whole centimetres.

Function
REQ-014 echo SHALL pass through a two-flop synchronizer; a third register SHALL hold the previous synchronized value for edge detection.
REQ-015 Rise SHALL be defined as synced=1 with prev=0, and fall as synced=0 with prev=1.
REQ-016 The FSM SHALL have the states IDLE, WAIT_RISE, MEASURE and REPORT.
REQ-017 IDLE with start=1 SHALL go to WAIT_RISE, clear the window counter and assert busy from the next cycle.
REQ-018 start SHALL be ignored in every state except IDLE.
REQ-019 WAIT_RISE on rise SHALL go to MEASURE and clear the microsecond prescaler, pulse counter and cm counter.
REQ-020 An echo already high at start acceptance SHALL NOT count as a rise; only a later low-to-high transition is accepted.
REQ-021 In MEASURE, the prescaler SHALL count 0..US_DIV-1; each wrap SHALL increment the pulse counter and the CM_DIV sub-counter.
REQ-022 Each wrap of the CM_DIV sub-counter at CM_DIV-1 SHALL increment the cm counter; partial intervals SHALL truncate.
REQ-023 The pulse counter SHALL saturate at 16'hFFFF, and the cm counter SHALL saturate at 10'h3FF.
REQ-024 MEASURE on fall SHALL go to REPORT; REPORT SHALL load pulse_us and distance_cm, pulse valid for one cycle, then return to IDLE with busy low.
REQ-025 valid SHALL be high exactly 2 clk edges after the first edge that samples echo low, i.e. at edge k+2 when edge k samples low.
REQ-026 The window counter SHALL run in WAIT_RISE and MEASURE and SHALL reach TIMEOUT_US*US_DIV cycles after start acceptance.
REQ-027 On expiry in either state, the block SHALL pulse timeout for one cycle, go to IDLE and leave pulse_us and distance_cm unchanged.
REQ-028 Fall and expiry in the same cycle SHALL resolve as a fall: valid is pulsed and timeout is not.
REQ-029 valid and timeout SHALL never be high in the same cycle.
REQ-030 pulse_us and distance_cm SHALL hold their values between reports.

Reset
REQ-031 On reset assertion, the FSM SHALL enter IDLE immediately and asynchronously.
REQ-032 On reset, busy, valid and timeout SHALL be 0, pulse_us SHALL be 0 and distance_cm SHALL be 0.
REQ-033 On reset, all counters and synchronizer flops SHALL be cleared.
REQ-034 Reset mid-measurement SHALL abort with no valid and no timeout pulse.
REQ-035 After reset release, the first start SHALL be accepted normally.

Verification
REQ-036 start, then echo high for 580 us (29000 cycles) -> valid pulse, pulse_us=580, distance_cm=10, busy low 1 cycle after valid.
REQ-037 start, then echo high for 57 us -> valid pulse, pulse_us=57, distance_cm=0.
REQ-038 start with echo held low -> timeout pulse 1_500_000 cycles after start acceptance, no valid, outputs unchanged from the prior measurement.
REQ-039 echo high before start, then low 1 us, then high 116 us -> pulse_us=116, distance_cm=2, and the pre-start high is ignored.
REQ-040 second start pulsed during MEASURE, then reset asserted mid-echo -> second start has no effect, reset aborts the measurement, all outputs read 0, no valid or timeout pulse, and the next measurement of 290 us reads distance_cm=5.
